// File: rtl/song_reader.sv
// song_reader: walks one 32-entry song in song_rom and issues {note, duration}
// words to the note player, counting each duration in beat strobes.
module song_reader #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int IDX_W  = 5,
    parameter int SONG_W = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       play,
    input  logic [SONG_W-1:0]          song,
    input  logic                       beat,
    output logic [SONG_W+IDX_W-1:0]    rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]    rom_dout,
    output logic [NOTE_W-1:0]          note,
    output logic                       new_note,
    output logic                       note_active,
    output logic                       song_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PLAYING,
        S_PAUSED,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = '1;
    localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);

    state_t              state;
    logic [IDX_W-1:0]    index;
    logic [SONG_W-1:0]   song_q;
    logic [DUR_W-1:0]    counter;
    logic [NOTE_W-1:0]   note_r;

    logic [NOTE_W-1:0]   dout_note;
    logic [DUR_W-1:0]    dout_dur;

    assign dout_note = rom_dout[NOTE_W+DUR_W-1:DUR_W];
    assign dout_dur  = rom_dout[DUR_W-1:0];

    // Address follows the live song input in IDLE so entry 0 is ready on start
    always_comb begin
        if (state == S_IDLE)
            rom_addr = {song, {IDX_W{1'b0}}};
        else
            rom_addr = {song_q, index};
    end

    // Sequencer FSM; outputs are registered on entry to the state they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            index       <= '0;
            song_q      <= '0;
            counter     <= '0;
            note_r      <= '0;
            note        <= '0;
            new_note    <= 1'b0;
            note_active <= 1'b0;
            song_done   <= 1'b0;
        end else begin
            new_note  <= 1'b0;
            song_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    note        <= '0;
                    note_active <= 1'b0;
                    if (play) begin
                        song_q <= song;
                        index  <= '0;
                        state  <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    note_r  <= dout_note;
                    counter <= dout_dur;
                    if (dout_dur == '0) begin
                        // Zero-duration entry: skip silently, note output untouched
                        if (index == LAST_IDX) begin
                            state     <= S_DONE;
                            song_done <= 1'b1;
                            note      <= '0;
                        end else begin
                            index <= index + IDX_W'(1);
                            state <= S_FETCH;
                        end
                    end else if (play) begin
                        state       <= S_PLAYING;
                        note        <= dout_note;
                        note_active <= 1'b1;
                        new_note    <= 1'b1;
                    end else begin
                        state <= S_PAUSED;
                        note  <= '0;
                    end
                end

                S_PLAYING: begin
                    // Expiry takes priority over a pause request; the pause is
                    // then honoured when the next entry reaches WAIT.
                    if (beat && counter == DUR_ONE) begin
                        counter     <= counter - DUR_ONE;
                        note_active <= 1'b0;
                        if (index == LAST_IDX) begin
                            state     <= S_DONE;
                            song_done <= 1'b1;
                            note      <= '0;
                        end else begin
                            index <= index + IDX_W'(1);
                            state <= S_FETCH;
                        end
                    end else if (!play) begin
                        state       <= S_PAUSED;
                        note        <= '0;
                        note_active <= 1'b0;
                    end else if (beat) begin
                        counter <= counter - DUR_ONE;
                    end
                end

                S_PAUSED: begin
                    if (play) begin
                        state       <= S_PLAYING;
                        note        <= note_r;
                        note_active <= 1'b1;
                        new_note    <= 1'b1;
                    end
                end

                S_DONE: begin
                    index <= '0;
                    note  <= '0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader: per-cycle vector table for the song0
// opening (latency, durations, rest, skip, pause), then hand-written
// sequences for mid-song reset and end-of-song looping.
module tb_song_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic [1:0]  song;
    logic        beat;
    logic [6:0]  rom_addr;
    logic [11:0] rom_dout;
    logic [5:0]  note;
    logic        new_note;
    logic        note_active;
    logic        song_done;

    logic [11:0] rom [0:127];

    int n_pass = 0;
    int n_total = 0;

    song_reader #(
        .NOTE_W(6),
        .DUR_W (6),
        .IDX_W (5),
        .SONG_W(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .play       (play),
        .song       (song),
        .beat       (beat),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .note       (note),
        .new_note   (new_note),
        .note_active(note_active),
        .song_done  (song_done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data valid the cycle after the address
    always @(posedge clk) rom_dout <= rom[rom_addr];

    typedef struct {
        bit play;
        bit beat;
        int addr;
        int note;
        bit nn;
        bit act;
    } vec_t;

    vec_t vecs [40];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] ent(input int n, input int d);
        logic [5:0] nn;
        logic [5:0] dd;
        nn = 6'(n);
        dd = 6'(d);
        return {nn, dd};
    endfunction

    initial begin
        int found;
        int nn_count;
        int last_note;
        int done_seen;

        for (int i = 0; i < 128; i++) rom[i] = ent(1, 1);
        // song0
        rom[0] = ent(37, 3);
        rom[1] = ent(35, 2);
        rom[2] = ent(0, 4);
        rom[3] = ent(41, 0);
        rom[4] = ent(42, 1);
        rom[5] = ent(47, 8);
        for (int i = 6; i < 32; i++) rom[i] = ent(i, 1);
        // song1
        for (int i = 0; i < 31; i++) rom[32 + i] = ent(i + 1, 1);
        rom[63] = ent(44, 1);
        // song2
        rom[64] = ent(55, 3);

        //                play beat addr note nn act
        vecs[0]  = '{1, 0, 0, 0,  0, 0};
        vecs[1]  = '{1, 0, 0, 0,  0, 0};
        vecs[2]  = '{1, 0, 0, 37, 1, 1};
        vecs[3]  = '{1, 0, 0, 37, 0, 1};
        vecs[4]  = '{1, 1, 0, 37, 0, 1};
        vecs[5]  = '{1, 0, 0, 37, 0, 1};
        vecs[6]  = '{1, 1, 0, 37, 0, 1};
        vecs[7]  = '{1, 0, 0, 37, 0, 1};
        vecs[8]  = '{1, 1, 1, 37, 0, 0};
        vecs[9]  = '{1, 0, 1, 37, 0, 0};
        vecs[10] = '{1, 0, 1, 35, 1, 1};
        vecs[11] = '{1, 1, 1, 35, 0, 1};
        vecs[12] = '{1, 1, 2, 35, 0, 0};
        vecs[13] = '{1, 0, 2, 35, 0, 0};
        vecs[14] = '{1, 0, 2, 0,  1, 1};
        vecs[15] = '{1, 1, 2, 0,  0, 1};
        vecs[16] = '{1, 1, 2, 0,  0, 1};
        vecs[17] = '{1, 1, 2, 0,  0, 1};
        vecs[18] = '{1, 1, 3, 0,  0, 0};
        vecs[19] = '{1, 0, 3, 0,  0, 0};
        vecs[20] = '{1, 0, 4, 0,  0, 0};
        vecs[21] = '{1, 0, 4, 0,  0, 0};
        vecs[22] = '{1, 0, 4, 42, 1, 1};
        vecs[23] = '{1, 1, 5, 42, 0, 0};
        vecs[24] = '{1, 0, 5, 42, 0, 0};
        vecs[25] = '{1, 0, 5, 47, 1, 1};
        vecs[26] = '{1, 1, 5, 47, 0, 1};
        vecs[27] = '{1, 1, 5, 47, 0, 1};
        vecs[28] = '{1, 1, 5, 47, 0, 1};
        vecs[29] = '{0, 1, 5, 0,  0, 0};
        vecs[30] = '{0, 1, 5, 0,  0, 0};
        vecs[31] = '{0, 0, 5, 0,  0, 0};
        vecs[32] = '{0, 1, 5, 0,  0, 0};
        vecs[33] = '{0, 1, 5, 0,  0, 0};
        vecs[34] = '{1, 0, 5, 47, 1, 1};
        vecs[35] = '{1, 1, 5, 47, 0, 1};
        vecs[36] = '{1, 1, 5, 47, 0, 1};
        vecs[37] = '{1, 1, 5, 47, 0, 1};
        vecs[38] = '{1, 1, 5, 47, 0, 1};
        vecs[39] = '{1, 1, 6, 47, 0, 0};

        // Reset and idle
        reset = 1'b1; play = 1'b0; song = 2'd0; beat = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_addr", int'(rom_addr), 0);
        chk("rst_note", int'(note), 0);
        chk("rst_new", int'(new_note), 0);
        chk("rst_act", int'(note_active), 0);
        chk("rst_done", int'(song_done), 0);
        step(); step();
        chk("idle_hold_act", int'(note_active), 0);
        chk("idle_hold_new", int'(new_note), 0);

        // Table: song0 opening
        for (int i = 0; i < 40; i++) begin
            play = vecs[i].play;
            beat = vecs[i].beat;
            step();
            chk($sformatf("v%0d_addr", i), int'(rom_addr), vecs[i].addr);
            chk($sformatf("v%0d_note", i), int'(note), vecs[i].note);
            chk($sformatf("v%0d_new", i), int'(new_note), int'(vecs[i].nn));
            chk($sformatf("v%0d_act", i), int'(note_active), int'(vecs[i].act));
            chk($sformatf("v%0d_done", i), int'(song_done), 0);
        end

        // Run on to index 17, then reset mid-note
        play = 1'b1; beat = 1'b1;
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            step();
            if (new_note && note == 6'd17) found = 1;
        end
        chk("reach_idx17", found, 1);
        chk("idx17_addr", int'(rom_addr), 17);
        reset = 1'b1; play = 1'b0; beat = 1'b0;
        step();
        reset = 1'b0;
        chk("midrst_addr", int'(rom_addr), 0);
        chk("midrst_note", int'(note), 0);
        chk("midrst_act", int'(note_active), 0);
        chk("midrst_new", int'(new_note), 0);
        chk("midrst_done", int'(song_done), 0);
        play = 1'b1;
        step();
        chk("restart_addr", int'(rom_addr), 0);
        chk("restart_act", int'(note_active), 0);
        step(); step();
        chk("restart_new", int'(new_note), 1);
        chk("restart_note", int'(note), 37);

        // End of song and loop; song change mid-song must be ignored
        reset = 1'b1; play = 1'b0; song = 2'd1;
        step();
        reset = 1'b0;
        play = 1'b1; beat = 1'b1;
        nn_count = 0; last_note = -1; done_seen = 0;
        for (int c = 0; c < 400 && done_seen == 0; c++) begin
            step();
            if (new_note) begin
                nn_count++;
                last_note = int'(note);
                if (nn_count == 10) begin
                    song = 2'd2;
                    #1;
                    chk("song_ignored", int'(rom_addr >> 5), 1);
                end
            end
            if (song_done) done_seen = 1;
        end
        chk("done_seen", done_seen, 1);
        chk("notes_in_song1", nn_count, 32);
        chk("last_note", last_note, 44);
        chk("done_note", int'(note), 0);
        chk("done_act", int'(note_active), 0);
        step();
        chk("done_pulse_len", int'(song_done), 0);
        chk("loop_idle_addr", int'(rom_addr), 64);
        step(); step();
        chk("loop_no_early_new", int'(new_note), 0);
        step();
        chk("loop_new", int'(new_note), 1);
        chk("loop_note", int'(note), 55);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/song_reader.md
Name: song_reader

Overview:
- Sequencer directly downstream of song_rom.
- Walks the 32 entries of one selected song and issues each {note, duration} word to the note player.
- Counts duration in beat strobes, one beat = 1/48 s, generated elsewhere.
- Handles rests, zero-duration entries, pause/resume, end-of-song signalling and looping.

Parameters:
NOTE_W, 6, note number width; 0 = rest
DUR_W, 6, duration width in beats
IDX_W, 5, note index width (32 entries per song)
SONG_W, 2, song select width; rom_addr = {song, index}

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
play  in  1  level; 1 = run, 0 = pause/stop
song  in  SONG_W  song select, sampled on leaving IDLE
beat  in  1  one-cycle beat strobe
rom_addr  out  SONG_W+IDX_W  address to song_rom
rom_dout  in  NOTE_W+DUR_W  song_rom data {note, duration}; valid one cycle after rom_addr
note  out  NOTE_W  current note to note player
new_note  out  1  one-cycle pulse when note (re)starts
note_active  out  1  high while a note/rest is sounding (PLAYING)
song_done  out  1  one-cycle pulse at end of song

Behaviour:
- Clock and reset:
  - Single clock clk. Reset is synchronous, active-high, and wins from any state.
  - On reset: state=IDLE, index=0, song_q=0, counter=0, note=0, all pulses/flags 0.
- Addressing:
  - rom_addr = {song_q, index}, combinational from registers.
  - In IDLE, rom_addr = {song, 0}.
- IDLE:
  - note=0, note_active=0.
  - If play=1: song_q<=song, index<=0, go to FETCH.
- FETCH:
  - Present address; go to WAIT unconditionally.
- WAIT:
  - rom_dout is valid this cycle; capture note_r<=dout[11:6], counter<=dout[5:0].
  - If duration==0: skip the entry, no new_note. If index==31 go to DONE, else index+1 and go to FETCH.
  - Else if play=1: go to PLAYING. Else go to PAUSED.
- PLAYING:
  - note=note_r, note_active=1.
  - new_note=1 in the first PLAYING cycle after WAIT or PAUSED.
  - beat=1 decrements counter, including a beat in the new_note cycle.
  - When beat=1 and counter==1: if index==31 go to DONE, else index+1 and go to FETCH.
  - If play=0 and not expiring this cycle: go to PAUSED; a coincident beat is ignored.
  - If expiry and play=0 occur together: expiry wins, and the pause takes effect at the next WAIT.
- PAUSED:
  - note=0, note_active=0; counter and index frozen; beat ignored.
  - If play=1: go to PLAYING (new_note pulses there).
- DONE:
  - song_done=1 for exactly this cycle; note=0; index<=0; go to IDLE.
  - If play is still 1, IDLE restarts next cycle, so the song loops; song is re-sampled then.
- Inter-note gap:
  - During FETCH/WAIT between notes, note holds the previous note_r and note_active=0.
  - Gap is 2 cycles of note_active low between consecutive notes.
- Rests:
  - note 0 is treated as a normal note: new_note pulses with note=0 and duration is counted.
- Song input:
  - Changes on song outside IDLE are ignored until the next IDLE.
- Start latency:
  - play sampled 1 in IDLE at cycle N: FETCH at N+1, WAIT at N+2, PLAYING with new_note=1 at N+3.
- Widths:
  - counter is DUR_W bits and never underflows, since expiry occurs at 1.
  - index is IDX_W bits; wrap to 0 occurs only through DONE.

Test Plan:
- Start latency: ROM song0 entry0={37,3}; reset, then play=1 at cycle 10 -> rom_addr=0 at cycle 11; note=37 and new_note=1 at cycle 13 only.
- Duration count: entry0={37,3}, entry1={35,2}; 3 beats spaced 5 cycles -> note_active drops after the 3rd beat; rom_addr=1; new_note with note=35 two cycles later.
- Rest and skip: entry2={0,4}, entry3={41,0}, entry4={42,1} -> new_note with note=0 held for 4 beats; entry3 produces no new_note; next new_note has note=42.
- End and loop: song1 entry31={44,1}, play held high -> song_done pulses once after that beat; rom_addr returns to {1,0}; new_note with entry0's note 4 cycles after song_done.
- Pause/resume: during a {47,8} note after 3 beats, play=0 for 20 cycles with 4 beats applied -> note=0, note_active=0, no decrement; after play=1, new_note pulses with note=47 and exactly 5 further beats end the note.
- Reset mid-song: reset=1 for 1 cycle while PLAYING at index 17 -> next cycle all outputs 0, IDLE; with play=1, restart fetches index 0.
